// File: rtl/mac_lookup_ctrl.sv
`timescale 1ns/1ps
// Lookup front-end for the two-bucket MAC table: learn the source, look up the
// destination, return an egress portmap, and raise periodic aging sweeps.
module mac_lookup_ctrl #(
  parameter logic [15:0] PORT_MASK    = 16'hFFFF,
  parameter logic [31:0] AGING_PERIOD = 32'd50_000_000,
  parameter logic [15:0] SE_TIMEOUT   = 16'd64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        lk_req,
  input  logic [47:0] lk_da,
  input  logic [47:0] lk_sa,
  input  logic [15:0] lk_portmap,
  output logic        lk_ack,
  output logic [15:0] lk_result,
  output logic        se_source,
  output logic [47:0] se_mac,
  output logic [15:0] se_portmap,
  output logic [9:0]  se_hash,
  output logic        se_req,
  input  logic        se_ack,
  input  logic        se_nak,
  input  logic [15:0] se_result,
  output logic        aging_req,
  input  logic        aging_ack
);

  typedef enum logic [1:0] {IDLE, LEARN, LOOKUP, DONE} state_t;

  state_t      state, state_nxt;
  logic [47:0] da_p0, sa_p0;
  logic [15:0] ing_p0;
  logic [15:0] to_cnt;
  logic [31:0] age_cnt;
  logic        resp, timeout, xact_end, da_mc, age_wrap;
  logic [15:0] flood, look_res;

  function automatic logic [9:0] mac_hash(input logic [47:0] m);
    return m[9:0] ^ m[19:10] ^ m[29:20] ^ m[39:30] ^ {2'b00, m[47:40]};
  endfunction

  assign da_mc    = da_p0[40];
  assign flood    = PORT_MASK & ~ing_p0;
  assign resp     = se_req && (se_ack || se_nak);
  assign timeout  = se_req && !resp && (to_cnt == SE_TIMEOUT - 16'd1);
  assign xact_end = resp || timeout;
  assign age_wrap = (age_cnt == AGING_PERIOD - 32'd1);

  // A simultaneous ack+nak counts as a miss, so only a clean ack uses the table result.
  always_comb begin
    look_res = flood;
    if (se_req && se_ack && !se_nak)
      look_res = se_result & ~ing_p0 & PORT_MASK;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lk_req) state_nxt = lk_sa[40] ? LOOKUP : LEARN;
      LEARN:   if (xact_end) state_nxt = LOOKUP;
      LOOKUP:  if (da_mc || xact_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lk_ack     = (state == DONE);
    se_source  = (state == LEARN);
    se_mac     = '0;
    se_portmap = '0;
    if (state == LEARN) begin
      se_mac     = sa_p0;
      se_portmap = ing_p0;
    end else if (state == LOOKUP && !da_mc) begin
      se_mac = da_p0;
    end
    se_hash = mac_hash(se_mac);
  end

  // Header capture stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      da_p0  <= '0;
      sa_p0  <= '0;
      ing_p0 <= '0;
    end else if (state == IDLE && lk_req) begin
      da_p0  <= lk_da;
      sa_p0  <= lk_sa;
      ing_p0 <= lk_portmap;
    end
  end

  // se_req rises one cycle after entering a table state and falls with the exit,
  // which leaves a low cycle between the learn and the lookup transactions.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      se_req <= 1'b0;
      to_cnt <= '0;
    end else begin
      if (xact_end)
        se_req <= 1'b0;
      else if (!se_req && (state == LEARN || (state == LOOKUP && !da_mc)))
        se_req <= 1'b1;
      if (!se_req || xact_end) to_cnt <= '0;
      else                     to_cnt <= to_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      lk_result <= '0;
    else if (state == LOOKUP && state_nxt == DONE)
      lk_result <= look_res;
  end

  // Aging ticks arriving while a sweep is outstanding are dropped, not queued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      age_cnt   <= '0;
      aging_req <= 1'b0;
    end else begin
      age_cnt <= age_wrap ? 32'd0 : age_cnt + 32'd1;
      if (aging_req) begin
        if (aging_ack) aging_req <= 1'b0;
      end else if (age_wrap) begin
        aging_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_lookup_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for mac_lookup_ctrl: a table stub answers after N request
// cycles; expected table transactions and lookup results are queued per request.
module tb_mac_lookup_ctrl;

  localparam int N       = 5;
  localparam int TO_LEN  = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        lk_req;
  logic [47:0] lk_da, lk_sa;
  logic [15:0] lk_portmap;
  logic        lk_ack;
  logic [15:0] lk_result;
  logic        se_source;
  logic [47:0] se_mac;
  logic [15:0] se_portmap;
  logic [9:0]  se_hash;
  logic        se_req;
  logic        se_ack = 1'b0;
  logic        se_nak = 1'b0;
  logic [15:0] se_result = 16'h0;
  logic        aging_req;
  logic        aging_ack;

  always #5 clk = ~clk;

  mac_lookup_ctrl #(
    .PORT_MASK(16'hFFFF),
    .AGING_PERIOD(32'd20),
    .SE_TIMEOUT(16'd8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .lk_req(lk_req), .lk_da(lk_da), .lk_sa(lk_sa), .lk_portmap(lk_portmap),
    .lk_ack(lk_ack), .lk_result(lk_result),
    .se_source(se_source), .se_mac(se_mac), .se_portmap(se_portmap),
    .se_hash(se_hash), .se_req(se_req),
    .se_ack(se_ack), .se_nak(se_nak), .se_result(se_result),
    .aging_req(aging_req), .aging_ack(aging_ack)
  );

  typedef struct {
    logic        src;
    logic [47:0] mac;
    logic [9:0]  hash;
    logic [15:0] pm;
    int          len;
  } se_exp_t;

  typedef struct {
    logic [15:0] res;
    int          lat;
  } lk_exp_t;

  se_exp_t se_q[$];
  lk_exp_t lk_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int t_sample = 0;
  int ack_cnt = 0;
  int cur_cyc = 0;
  int learn_mode = 0;   // 0 ack, 1 nak, 2 silent, 3 ack+nak
  int lookup_mode = 0;
  int stub_mode = 0;
  int hi_cnt = 0;
  logic [15:0] stub_res = 16'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Table stub: responds in the N-th cycle that se_req is high.
  always @(negedge clk) begin
    se_ack = 1'b0;
    se_nak = 1'b0;
    se_result = 16'h0;
    if (rstn && se_req) begin
      hi_cnt++;
      if (hi_cnt == N) begin
        stub_mode = se_source ? learn_mode : lookup_mode;
        case (stub_mode)
          0: begin se_ack = 1'b1; se_result = stub_res; end
          1: se_nak = 1'b1;
          3: begin se_ack = 1'b1; se_nak = 1'b1; se_result = stub_res; end
          default: ;
        endcase
      end
    end else begin
      hi_cnt = 0;
    end
  end

  // Monitor: pops expectations when the DUT starts a table request or acks a lookup.
  logic    se_prev = 1'b0;
  logic    have_cur = 1'b0;
  int      hi = 0;
  se_exp_t mon_se;
  lk_exp_t mon_lk;

  always @(negedge clk) begin
    if (!rstn) begin
      se_prev = 1'b0;
      have_cur = 1'b0;
    end else begin
      if (se_req && !se_prev) begin
        if (se_q.size() == 0) begin
          chk("se_req_unexpected", 1, 0);
          have_cur = 1'b0;
        end else begin
          mon_se = se_q.pop_front();
          have_cur = 1'b1;
          hi = 1;
          chk("se_source", se_source, mon_se.src);
          chk("se_mac", se_mac, mon_se.mac);
          chk("se_hash", se_hash, mon_se.hash);
          chk("se_portmap", se_portmap, mon_se.pm);
        end
      end else if (se_req) begin
        hi++;
      end else if (se_prev && have_cur) begin
        chk("se_req_len", hi, mon_se.len);
        have_cur = 1'b0;
      end
      se_prev = se_req;
      if (lk_ack) begin
        ack_cnt++;
        if (lk_q.size() == 0) begin
          chk("lk_ack_unexpected", 1, 0);
        end else begin
          mon_lk = lk_q.pop_front();
          chk("lk_result", lk_result, mon_lk.res);
          chk("lk_latency", cyc - t_sample, mon_lk.lat);
        end
      end
    end
  end

  task automatic wait_to(input int k);
    repeat (k - cur_cyc) @(negedge clk);
    cur_cyc = k;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    cur_cyc = 0;
  endtask

  task automatic run_lk(input logic [47:0] sa, input logic [47:0] da, input logic [15:0] pm,
                        input int lmode, input int kmode, input logic [15:0] sres,
                        input logic do_learn, input logic do_lookup,
                        input logic [9:0] h_sa, input logic [9:0] h_da,
                        input logic [15:0] exp_res, input int exp_lat, input logic busy);
    se_exp_t e;
    lk_exp_t l;
    int start;
    learn_mode = lmode;
    lookup_mode = kmode;
    stub_res = sres;
    if (do_learn) begin
      e.src = 1'b1; e.mac = sa; e.hash = h_sa; e.pm = pm;
      e.len = (lmode == 2) ? TO_LEN : N;
      se_q.push_back(e);
    end
    if (do_lookup) begin
      e.src = 1'b0; e.mac = da; e.hash = h_da; e.pm = 16'h0;
      e.len = (kmode == 2) ? TO_LEN : N;
      se_q.push_back(e);
    end
    l.res = exp_res;
    l.lat = exp_lat;
    lk_q.push_back(l);
    start = ack_cnt;
    @(negedge clk);
    lk_sa = sa; lk_da = da; lk_portmap = pm; lk_req = 1'b1;
    t_sample = cyc;
    @(negedge clk);
    lk_req = 1'b0;
    if (busy) begin
      repeat (2) @(negedge clk);
      lk_req = 1'b1; lk_sa = 48'h0A0B0C0D0E0F; lk_portmap = 16'h0001;
      @(negedge clk);
      lk_req = 1'b0;
      repeat (4) @(negedge clk);
      lk_req = 1'b1;
      @(negedge clk);
      lk_req = 1'b0;
    end
    for (int i = 0; i < 300 && ack_cnt == start; i++) @(negedge clk);
    if (ack_cnt == start) chk("lk_ack_timeout", 0, 1);
    @(negedge clk);
    chk("lk_result_hold", lk_result, exp_res);
    chk("lk_ack_single", lk_ack, 0);
    repeat (3) @(negedge clk);
  endtask

  localparam logic [47:0] SA  = 48'h001122334455;
  localparam logic [47:0] DA  = 48'h66778899AABB;
  localparam logic [47:0] BC  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] MSA = 48'h01005E000001;
  localparam logic [9:0]  HSA = 10'h2E3;
  localparam logic [9:0]  HDA = 10'h1E0;

  initial begin
    rstn = 1'b0;
    lk_req = 1'b0; lk_da = '0; lk_sa = '0; lk_portmap = '0;
    aging_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_lk_ack", lk_ack, 0);
    chk("rst_lk_result", lk_result, 0);
    chk("rst_se_req", se_req, 0);
    chk("rst_se_mac", se_mac, 0);
    chk("rst_se_hash", se_hash, 0);
    chk("rst_aging_req", aging_req, 0);
    rstn = 1'b1;
    cur_cyc = 0;

    // Aging: rise, acknowledged clear, next rise.
    wait_to(19); chk("aging_c19", aging_req, 0);
    wait_to(20); chk("aging_rise", aging_req, 1);
    wait_to(30); chk("aging_c30", aging_req, 1); aging_ack = 1'b1;
    wait_to(31); aging_ack = 1'b0; chk("aging_clear", aging_req, 0);
    wait_to(40); chk("aging_rise2", aging_req, 1);

    // Aging: a tick during an active sweep is discarded.
    do_reset();
    wait_to(20); chk("agingB_rise", aging_req, 1);
    wait_to(45); aging_ack = 1'b1;
    wait_to(46); aging_ack = 1'b0; chk("agingB_clear", aging_req, 0);
    wait_to(59); chk("agingB_no_queue", aging_req, 0);
    wait_to(60); chk("agingB_rise2", aging_req, 1);
    wait_to(62);
    rstn = 1'b0;
    #1 chk("aging_async_reset", aging_req, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_lk(SA, DA, 16'h0004, 0, 0, 16'h0010, 1, 1, HSA, HDA, 16'h0010, 2*N+3, 0);
    run_lk(SA, DA, 16'h0004, 0, 1, 16'h0010, 1, 1, HSA, HDA, 16'hFFFB, 2*N+3, 0);
    run_lk(SA, BC, 16'h0004, 0, 0, 16'h0010, 1, 0, HSA, HDA, 16'hFFFB, N+3, 0);
    run_lk(MSA, DA, 16'h0004, 0, 0, 16'h0010, 0, 1, HSA, HDA, 16'h0010, N+2, 0);
    run_lk(MSA, BC, 16'h0004, 0, 0, 16'h0010, 0, 0, HSA, HDA, 16'hFFFB, 2, 0);
    run_lk(SA, DA, 16'h0004, 0, 0, 16'h0004, 1, 1, HSA, HDA, 16'h0000, 2*N+3, 0);
    run_lk(SA, DA, 16'h0004, 1, 0, 16'h0014, 1, 1, HSA, HDA, 16'h0010, 2*N+3, 0);
    run_lk(SA, DA, 16'h0004, 0, 3, 16'h0010, 1, 1, HSA, HDA, 16'hFFFB, 2*N+3, 0);
    run_lk(SA, DA, 16'h8000, 0, 0, 16'hFFFF, 1, 1, HSA, HDA, 16'h7FFF, 2*N+3, 0);
    run_lk(SA, DA, 16'h0004, 2, 2, 16'h0010, 1, 1, HSA, HDA, 16'hFFFB, 2*TO_LEN+3, 0);
    run_lk(SA, DA, 16'h0004, 0, 0, 16'h0010, 1, 1, HSA, HDA, 16'h0010, 2*N+3, 1);

    repeat (20) @(negedge clk);
    chk("se_q_empty", se_q.size(), 0);
    chk("lk_q_empty", lk_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_lookup_ctrl.md
Name: mac_lookup_ctrl

Overview:
Front-end controller for the two-bucket MAC table. It accepts one frame-header lookup at a time from the ingress arbiter and computes the 10-bit bucket hash. It sequences a source-learn transaction and then a destination-lookup transaction on the table's se_* handshake, and returns a forwarding portmap to the arbiter. It also generates the periodic aging_req sweep request for the table.

Parameters:
PORT_MASK, 16'hFFFF, ports that exist; the flood set is PORT_MASK & ~ingress.
AGING_PERIOD, 32'd50_000_000, clk cycles between aging sweep starts (must be >= 2).
SE_TIMEOUT, 16'd64, max cycles to wait for se_ack/se_nak before abandoning a transaction.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
lk_req  in  1  lookup request; level, sampled only in IDLE
lk_da  in  48  destination MAC; bit 40 = I/G bit
lk_sa  in  48  source MAC
lk_portmap  in  16  one-hot ingress port
lk_ack  out  1  one-cycle pulse; lk_result is valid in that cycle
lk_result  out  16  egress portmap; 0 = drop
se_source  out  1  1 = learn, 0 = lookup
se_mac  out  48  MAC under search
se_portmap  out  16  portmap to learn
se_hash  out  10  bucket address
se_req  out  1  table request
se_ack  in  1  table accept/hit pulse
se_nak  in  1  table reject/miss pulse
se_result  in  16  lookup portmap; valid with se_ack
aging_req  out  1  aging sweep request; level
aging_ack  in  1  sweep-complete pulse

Behaviour:
- Reset (async, rstn=0): state IDLE. All outputs are 0. Captured header registers and both counters are cleared. A reset mid-transaction abandons the transaction with no lk_ack.
- Hash, combinational on the MAC driven: hash = m[9:0]^m[19:10]^m[29:20]^m[39:30]^{2'b0,m[47:40]}.
- States:
  - IDLE: if lk_req=1, capture da/sa/portmap and accept one request; lk_req is ignored in all other states. Next state is LEARN if sa[40]=0, else LOOKUP.
  - LEARN: drive se_source=1, se_mac=sa, se_portmap=ingress, se_hash=hash(sa), se_req=1.
  - LOOKUP: if da[40]=1 (broadcast/multicast), no table access; go to DONE with result = flood set. Otherwise drive se_source=0, se_mac=da, se_portmap=0, se_hash=hash(da), se_req=1.
  - DONE: lk_ack=1 for one cycle; then IDLE.
- Handshake with the table:
  - se_req and all se_* fields stay stable from assertion until the cycle se_ack or se_nak is seen high.
  - se_req deasserts on the clock edge following that cycle, so it is low while the table returns to its idle state; no double issue.
  - A transaction waiting on the table (e.g. during the table's post-reset clear) is held, not dropped.
- Responses:
  - In LEARN, ack or nak both advance to LOOKUP. A nak means both buckets are full; the entry is not learned and the frame is still forwarded.
  - In LOOKUP, se_ack gives result = se_result & ~ingress & PORT_MASK (0 means drop, same-port filtering). se_nak gives result = flood set.
  - se_ack and se_nak high together is treated as nak.
- Timeout: a counter starts at each se_req rising edge. When it reaches SE_TIMEOUT with no response, drop se_req. LEARN proceeds to LOOKUP; LOOKUP proceeds to DONE with the flood set.
- lk_result updates only in the DONE cycle and holds otherwise.
- Latency with a table responding in N cycles: learn+lookup = 2N+3 cycles from lk_req sample to lk_ack. Multicast SA and multicast DA = 2 cycles.
- Aging:
  - A free-running counter counts 0..AGING_PERIOD-1 and wraps.
  - On wrap, if aging_req=0, set aging_req=1. If a sweep is already active, the tick is discarded (no queueing).
  - aging_req clears on the cycle after aging_ack=1.
  - aging_req is independent of the lookup FSM; the table gives se_req priority over aging.

Test Plan:
- After reset, IDLE with a table stub that answers N=5: lk_req, sa=00:11:22:33:44:55, da=66:77:88:99:AA:BB, portmap=0x0004; learn acks, lookup acks with 0x0010 -> one learn then one lookup in order; se_hash matches the formula; lk_ack pulses once with lk_result=0x0010 at cycle 2N+3.
- Same request, lookup answered by se_nak -> lk_result=0xFFFB (flood minus port 2).
- DA=FF:FF:FF:FF:FF:FF -> learn only, no lookup se_req; lk_result=0xFFFB. Separately, sa[40]=1 -> no learn transaction.
- Lookup acked with se_result=0x0004 on ingress 0x0004 -> lk_result=0x0000. Learn nak'd -> lookup still issued.
- Table stub silent, SE_TIMEOUT=8 -> se_req drops after 8 cycles in each state; lk_result=flood. Second case: lk_req pulses while busy are ignored.
- AGING_PERIOD=20: aging_req rises at cycle 20; aging_ack at 30 -> aging_req low at 31. Stub acks at 45 so the wrap at 40 is discarded -> next rise at 60. Reset asserted mid-sweep -> aging_req=0 immediately.
